sync_debounce: RTL

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_pkg.sv | 22 ++
 rtl/sync_debounce_ch.sv | 86 ++++++++
 rtl/sync_debounce.sv | 112 +++++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg
// Shared constants for the sync_debounce block: default parameter values,
// legal parameter ranges and the per-channel filter counter width helper.
// ---------------------------------------------------------------------------
package sync_pkg;

   localparam int DEF_CHANNELS   = 9;
   localparam int DEF_STAGES     = 2;
   localparam int DEF_FILTER_CNT = 4;

   localparam int MIN_STAGES     = 2;
   localparam int MAX_STAGES     = 4;
   localparam int MIN_FILTER_CNT = 1;
   localparam int MAX_FILTER_CNT = 255;

   // Width of a counter that must be able to hold 0..filter_cnt.
   function automatic int cnt_width(input int filter_cnt);
      return $clog2(filter_cnt + 1);
   endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// ---------------------------------------------------------------------------
// sync_debounce_ch
// One debounce channel: stability counter, filtered output level and the
// registered rise/fall edge pulses.
//
// Ports
//   clk_ab      : clock, posedge
//   rst_ab      : synchronous active-low reset
//   filt_en     : 1 = filter active, 0 = bypass (output follows sync_in)
//   mode_switch : high on the edge where filt_en differs from its last value
//   sync_in     : synchronized input level for this channel
//   data_out    : filtered level (registered)
//   rise / fall : one-cycle pulses when data_out changes 0->1 / 1->0
//   change_next : combinational strobe, high when data_out updates this edge
// ---------------------------------------------------------------------------
module sync_debounce_ch
   import sync_pkg::*;
#(
   parameter int FILTER_CNT = DEF_FILTER_CNT
) (
   input  logic clk_ab,
   input  logic rst_ab,
   input  logic filt_en,
   input  logic mode_switch,
   input  logic sync_in,
   output logic data_out,
   output logic rise,
   output logic fall,
   output logic change_next
);

   localparam int CW = cnt_width(FILTER_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          out_reg;
   logic          out_next;
   logic          rise_reg;
   logic          fall_reg;

   always_comb begin
      cnt_next    = cnt_reg;
      out_next    = out_reg;
      change_next = 1'b0;
      if (mode_switch) begin
         // Mode change: drop any partial count and hold the output for one
         // edge; the newly selected mode takes over from the next edge.
         cnt_next = '0;
      end else if (!filt_en) begin
         cnt_next = '0;
         if (sync_in != out_reg) begin
            out_next    = sync_in;
            change_next = 1'b1;
         end
      end else if (sync_in == out_reg) begin
         cnt_next = '0;
      end else if (cnt_reg < CNT_LAST) begin
         cnt_next = cnt_reg + 1'b1;
      end else begin
         // The count is cleared here, so it never exceeds CNT_LAST.
         cnt_next    = '0;
         out_next    = sync_in;
         change_next = 1'b1;
      end
   end

   always_ff @(posedge clk_ab) begin
      if (!rst_ab) begin
         cnt_reg  <= '0;
         out_reg  <= 1'b0;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         out_reg  <= out_next;
         rise_reg <= change_next & sync_in;
         fall_reg <= change_next & ~sync_in;
      end
   end

   assign data_out = out_reg;
   assign rise     = rise_reg;
   assign fall     = fall_reg;

endmodule

// File: rtl/sync_debounce.sv
// ---------------------------------------------------------------------------
// sync_debounce
// Multi-channel synchronizer plus debounce filter with edge detection.
// Each data_in bit passes through a STAGES-deep flop chain and is then
// filtered so that data_out only changes after FILTER_CNT consecutive
// cycles of a differing synchronized level (or every cycle in bypass).
//
// Ports
//   clk_ab   : sole clock, posedge
//   rst_ab   : synchronous active-low reset
//   filt_en  : 1 = debounce filter active, 0 = bypass filter
//   data_in  : [CHANNELS] asynchronous / noisy level inputs
//   data_out : [CHANNELS] synchronized, filtered levels (registered)
//   rise     : [CHANNELS] one-cycle pulse per data_out 0->1 transition
//   fall     : [CHANNELS] one-cycle pulse per data_out 1->0 transition
//   changed  : one-cycle pulse when any data_out bit changes
// ---------------------------------------------------------------------------
module sync_debounce
   import sync_pkg::*;
#(
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int STAGES     = DEF_STAGES,
   parameter int FILTER_CNT = DEF_FILTER_CNT
) (
   input  logic                clk_ab,
   input  logic                rst_ab,
   input  logic                filt_en,
   input  logic [CHANNELS-1:0] data_in,
   output logic [CHANNELS-1:0] data_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                changed
);

   generate
      if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
         $error("sync_debounce: STAGES=%0d outside %0d..%0d", STAGES, MIN_STAGES, MAX_STAGES);
      end
      if (FILTER_CNT < MIN_FILTER_CNT || FILTER_CNT > MAX_FILTER_CNT) begin : g_bad_filter
         $error("sync_debounce: FILTER_CNT=%0d outside %0d..%0d", FILTER_CNT, MIN_FILTER_CNT,
                MAX_FILTER_CNT);
      end
      if (CHANNELS < 1) begin : g_bad_channels
         $error("sync_debounce: CHANNELS must be at least 1");
      end
   endgenerate

   logic [CHANNELS-1:0] sync_reg [STAGES];
   logic [CHANNELS-1:0] sync_val;
   logic                prev_en_reg;
   logic                mode_switch;
   logic [CHANNELS-1:0] change_next;
   logic                changed_reg;

   always_ff @(posedge clk_ab) begin
      if (!rst_ab) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_reg[i] <= '0;
         end
      end else begin
         sync_reg[0] <= data_in;
         for (int i = 1; i < STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
         end
      end
   end

   assign sync_val = sync_reg[STAGES-1];

   // Tracks filt_en even during reset so that a steady filt_en never looks
   // like a mode change on the first edge after release.
   always_ff @(posedge clk_ab) begin
      prev_en_reg <= filt_en;
   end

   assign mode_switch = filt_en ^ prev_en_reg;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         sync_debounce_ch #(
            .FILTER_CNT (FILTER_CNT)
         ) u_ch (
            .clk_ab      (clk_ab),
            .rst_ab      (rst_ab),
            .filt_en     (filt_en),
            .mode_switch (mode_switch),
            .sync_in     (sync_val[gi]),
            .data_out    (data_out[gi]),
            .rise        (rise[gi]),
            .fall        (fall[gi]),
            .change_next (change_next[gi])
         );
      end
   endgenerate

   // Registered from the same strobes that load rise/fall, so changed lines
   // up with them exactly.
   always_ff @(posedge clk_ab) begin
      if (!rst_ab) begin
         changed_reg <= 1'b0;
      end else begin
         changed_reg <= |change_next;
      end
   end

   assign changed = changed_reg;

   a_rise_fall_exclusive : assert property (
      @(posedge clk_ab) disable iff (!rst_ab) (rise & fall) == '0
   ) else $error("sync_debounce: rise and fall asserted together");

endmodule
